// File: rtl/rr_arb_mux_nbit.sv
// M-channel, N-bit arbitrating multiplexer with a one-entry registered output and valid/ready handshakes.
// Define RR_ARB_MUX_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module rr_arb_mux_nbit #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int SEL_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M*N-1:0]   in_data,
  input  logic [M-1:0]     in_valid,
  output logic [M-1:0]     in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
);

  localparam int unsigned MU = M;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_next;
  logic             load;
  logic             any_req;
  logic [M-1:0]     grant;
  logic [SEL_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_data;
  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     ch_data [M];

  for (genvar i = 0; i < M; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*N +: N];
  end

  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;
  assign in_ready  = {M{load & ~rst}} & grant;

  // Scan starts at ptr and wraps modulo M, so non-power-of-2 M never indexes past M-1.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant    = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    any_req  = 1'b0;
    for (int unsigned k = 0; k < MU; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= MU) idx = idx - MU;
      if (!any_req && in_valid[SEL_W'(idx)]) begin
        any_req              = 1'b1;
        grant[SEL_W'(idx)]   = 1'b1;
        gnt_idx              = SEL_W'(idx);
        gnt_data             = ch_data[SEL_W'(idx)];
      end
    end
  end

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && any_req) begin
      ptr <= (gnt_idx == SEL_W'(M - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (any_req) state_next = FULL;
      FULL:    if (out_ready && !any_req) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (load && any_req) begin
      out_data <= gnt_data;
      out_sel  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_nbit.sv
// Self-checking bench for rr_arb_mux_nbit: directed scenarios plus randomized traffic
// against a queue-free behavioural model (M=4), and a second M=3 instance for pointer wrap.
module tb_rr_arb_mux_nbit;

  localparam int N = 32;
  localparam int M = 4;

  logic           clk;
  logic           rst;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_sel;

  logic [3*N-1:0] d3;
  logic [2:0]     v3;
  logic [2:0]     r3;
  logic [N-1:0]   od3;
  logic           ov3;
  logic           ordy3;
  logic [1:0]     os3;

  int vectors;
  int miscompares;

  // reference model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_ptr;

  rr_arb_mux_nbit #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  rr_arb_mux_nbit #(.N(N), .M(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .out_data(od3), .out_valid(ov3), .out_ready(ordy3), .out_sel(os3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [M-1:0] v, input int p);
    for (int k = 0; k < M; k++) begin
      int j;
      j = (p + k) % M;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] chan(input logic [M*N-1:0] d, input int c);
    logic [M*N-1:0] t;
    t = d >> (c * N);
    return t[31:0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // Inputs are already driven (just after a rising edge); check handshake, clock, check outputs.
  task automatic step(input string tag);
    bit ld;
    int g;
    logic [M-1:0] exp_rdy;
    #1;
    ld = !m_valid || out_ready;
    g  = pick(in_valid, m_ptr);
    exp_rdy = '0;
    if (ld && g >= 0) exp_rdy[g] = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (ld && g >= 0) begin
      m_valid = 1'b1;
      m_data  = chan(in_data, g);
      m_sel   = g;
      m_ptr   = (g + 1) % M;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(m_data));
      check({tag, ".out_sel"},  64'(out_sel),  64'(m_sel));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_seq[6];
    int exp3[4];
    logic [31:0] hold_data;
    vectors     = 0;
    miscompares = 0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    d3        = '0;
    v3        = '0;
    ordy3     = 1'b0;
    model_reset();
    do_reset();

    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.out_data",  64'(out_data),  64'd0);
    check("reset.out_sel",   64'(out_sel),   64'd0);

    // single source on channel 2
    in_data  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1 check("single.in_ready", 64'(in_ready), 64'h4);
    step("single");
    check("single.data_const", 64'(out_data), 64'hDEADBEEF);
    check("single.sel_const",  64'(out_sel),  64'd2);

    // round-robin from reset with all channels requesting
    in_valid = '0;
    do_reset();
    exp_seq = '{0, 1, 2, 3, 0, 1};
    in_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      check("rr.seq", 64'(out_sel), 64'(exp_seq[i]));
    end

    // backpressure while holding the channel-1 beat
    out_ready = 1'b0;
    hold_data = out_data;
    for (int i = 0; i < 5; i++) begin
      step("bp");
      check("bp.data_hold", 64'(out_data), 64'(hold_data));
      check("bp.sel_hold",  64'(out_sel),  64'd1);
    end
    out_ready = 1'b1;
    #1 check("bp.release_ready", 64'(in_ready), 64'h4);
    step("bp_release");
    check("bp.next_sel", 64'(out_sel), 64'd2);

    // drain to empty
    in_valid = '0;
    step("drain");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // reset asserted mid-transfer with a buffered beat
    in_valid  = 4'b0001;
    in_data   = {$urandom, $urandom, $urandom, 32'hCAFE_F00D};
    out_ready = 1'b1;
    step("pre_rst");
    check("pre_rst.full", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.out_data",  64'(out_data),  64'd0);
    check("midrst.out_sel",   64'(out_sel),   64'd0);
    check("midrst.in_ready",  64'(in_ready),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    in_valid = '0;

    // M=3 wrap: channels 0 and 2 alternate
    exp3 = '{0, 2, 0, 2};
    d3    = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    v3    = 3'b101;
    ordy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("m3.in_ready", 64'(r3), (exp3[i] == 0) ? 64'h1 : 64'h4);
      @(posedge clk);
      #1;
      check("m3.out_sel",   64'(os3), 64'(exp3[i]));
      check("m3.out_valid", 64'(ov3), 64'd1);
      check("m3.out_data",  64'(od3), (exp3[i] == 0) ? 64'hC0C0_C0C0 : 64'hC2C2_C2C2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
